life_host_seq: RTL and testbench
================================

LIFE_HOST_SEQ -- requirements
Module: life_host_seq

Interface
REQ-001 Parameters SHALL be: DWIDTH, default 32, bus data width. AWIDTH, default 8, bus address width. NWORDS, default 8, blocks in the scan chain. CWIDTH, default 8, generation counter width. CTRL_ID, default 8'hF0, control address. SCAN_ID, default 8'hF1, scan address.
REQ-002 Clk  input  1  single clock; all state SHALL update on posedge Clk.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request one load/run/unload job.
REQ-005 Generations  input  CWIDTH  number of generations for the job.
REQ-006 Busy  output  1  job in progress.
REQ-007 Done  output  1  one-cycle pulse at job end.
REQ-008 LoadData  input  DWIDTH  word to scan in.
REQ-009 LoadValid  input  1  LoadData is valid.
REQ-010 LoadReady  output  1  block accepts a load word.
REQ-011 StoreData  output  DWIDTH  word scanned out.
REQ-012 StoreValid  output  1  StoreData is valid.
REQ-013 StoreReady  input  1  consumer accepts StoreData.
REQ-014 BusRD, BusWR  output  1 each  global bus strobes; this block is the bus master.
REQ-015 BusAddr  output  AWIDTH  global bus address.
REQ-016 BusDataOut  output  DWIDTH  write data; drives the responders' DataIn.
REQ-017 BusDataIn  input  DWIDTH  read data; taken from the responders' DataOut.
REQ-018 Error  output  1  poll watchdog fired.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, RUN, POLL, UNLOAD, FINISH and ERR.
REQ-020 All bus outputs SHALL be registered; BusRD and BusWR SHALL never be high together.
REQ-021 In IDLE, Start high SHALL capture Generations, set Busy the next cycle and enter LOAD; Start SHALL be ignored while Busy.
REQ-022 LoadReady SHALL equal (state==LOAD).
REQ-023 Each LOAD handshake (LoadValid&&LoadReady at an edge) SHALL produce exactly one bus cycle on the next clock: BusWR=1, BusAddr=SCAN_ID, BusDataOut=LoadData.
REQ-024 After NWORDS handshakes the block SHALL leave LOAD; LoadValid low SHALL stall without issuing a bus cycle.
REQ-025 RUN SHALL issue one cycle of BusWR=1, BusAddr=CTRL_ID, BusDataOut=captured Generations zero-extended, then enter POLL.
REQ-026 If the captured Generations==0, RUN and POLL SHALL be skipped and the block SHALL go directly to UNLOAD.
REQ-027 POLL SHALL assert BusRD with BusAddr=CTRL_ID every cycle and sample BusDataIn[CWIDTH-1:0] in each BusRD cycle.
REQ-028 POLL SHALL exit to UNLOAD after the first sampled value of 0, with BusRD low on the following cycle.
REQ-029 UNLOAD SHALL issue BusRD=1, BusAddr=SCAN_ID for one cycle only when StoreValid is low and no read is in flight.
REQ-030 Each UNLOAD read SHALL capture BusDataIn at the end of its BusRD cycle into StoreData and set StoreValid.
REQ-031 StoreValid SHALL clear on a StoreValid&&StoreReady edge.
REQ-032 Exactly NWORDS unload reads SHALL occur.
REQ-033 Unload words SHALL emerge in the same order they were loaded, because the scan chain is FIFO-ordered.
REQ-034 After the last store handshake the block SHALL enter FINISH, pulse Done for one cycle, clear Busy the same cycle, and return to IDLE.
REQ-035 Load and unload word counters SHALL be ceil(log2(NWORDS+1)) bits wide and SHALL clear on entry to LOAD.

Reset
REQ-036 Reset SHALL have priority over every other input.
REQ-037 On the edge where Reset is sampled high, the state SHALL become IDLE and BusRD, BusWR, Busy, Done, StoreValid and Error SHALL become 0.
REQ-038 On that same edge BusAddr, BusDataOut, StoreData and all counters SHALL become 0.
REQ-039 Reset mid-job SHALL abort the job without completing the current bus cycle and SHALL NOT pulse Done.

Configuration
REQ-040 With macro LIFE_HOST_SEQ_TIMEOUT_EN defined, a POLL cycle counter SHALL run from POLL entry.
REQ-041 With LIFE_HOST_SEQ_TIMEOUT_EN defined, exceeding 2^CWIDTH+4 poll reads without seeing 0 SHALL move the block to ERR.
REQ-042 In ERR, Error SHALL be high, bus strobes SHALL be low and Busy SHALL stay high until Reset.
REQ-043 Without LIFE_HOST_SEQ_TIMEOUT_EN, POLL SHALL wait indefinitely, Error SHALL be constant 0, and no watchdog logic SHALL exist.

Verification
REQ-044 Basic job: NWORDS=8, Generations=3, loopback responder model, words 0x1..0x8 -> 8 SCAN_ID writes, one CTRL_ID write of 0x3, poll reads returning 3,2,1,0, 8 SCAN_ID reads, StoreData 0x1..0x8 in order, one Done pulse.
REQ-045 Generations=0 -> no bus cycle at CTRL_ID, UNLOAD starts directly after the eighth load write.
REQ-046 LoadValid toggled 1-0-1 and StoreReady held low 5 cycles -> no extra bus cycles, no lost or duplicated words, StoreData stable while stalled.
REQ-047 Reset asserted during the fourth load write -> all outputs 0 after that edge, no Done; a new Start then runs a full clean job.
REQ-048 Start re-asserted while Busy -> ignored, exactly one Done per accepted Start.
REQ-049 With LIFE_HOST_SEQ_TIMEOUT_EN defined and the control read held at 0x5 forever -> Error=1 after 260 poll reads, bus idle, Busy=1 until Reset.

Source files
------------

// File: rtl/life_host_seq.sv
// Bus-master sequencer for a scan-chain Life array: load words, run N generations, poll, unload.
// Optional poll watchdog enabled by defining LIFE_HOST_SEQ_TIMEOUT_EN.
module life_host_seq #(
  parameter int                DWIDTH  = 32,
  parameter int                AWIDTH  = 8,
  parameter int                NWORDS  = 8,
  parameter int                CWIDTH  = 8,
  parameter logic [AWIDTH-1:0] CTRL_ID = 8'hF0,
  parameter logic [AWIDTH-1:0] SCAN_ID = 8'hF1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [CWIDTH-1:0] Generations,
  output logic              Busy,
  output logic              Done,
  input  logic [DWIDTH-1:0] LoadData,
  input  logic              LoadValid,
  output logic              LoadReady,
  output logic [DWIDTH-1:0] StoreData,
  output logic              StoreValid,
  input  logic              StoreReady,
  output logic              BusRD,
  output logic              BusWR,
  output logic [AWIDTH-1:0] BusAddr,
  output logic [DWIDTH-1:0] BusDataOut,
  input  logic [DWIDTH-1:0] BusDataIn,
  output logic              Error
);

  localparam int NCW = $clog2(NWORDS + 1);
  localparam logic [NCW-1:0] LAST_WORD = NCW'(NWORDS - 1);
  localparam logic [NCW-1:0] ALL_WORDS = NCW'(NWORDS);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, POLL, UNLOAD, FINISH, ERR} state_t;

  state_t            state;
  logic [CWIDTH-1:0] gen_q;
  logic [NCW-1:0]    load_cnt;
  logic [NCW-1:0]    unload_cnt;

`ifdef LIFE_HOST_SEQ_TIMEOUT_EN
  localparam int POLL_LIMIT = (1 << CWIDTH) + 4;
  localparam logic [CWIDTH+1:0] POLL_LAST = (CWIDTH+2)'(POLL_LIMIT - 1);
  logic [CWIDTH+1:0] poll_cnt;
`else
  assign Error = 1'b0;
`endif

  assign LoadReady = (state == LOAD);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      // NOTE: reset is sampled on the clock edge, so it lives inside the clocked block and wins over every branch below.
      state      <= IDLE;
      gen_q      <= '0;
      load_cnt   <= '0;
      unload_cnt <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      StoreData  <= '0;
      StoreValid <= 1'b0;
      BusRD      <= 1'b0;
      BusWR      <= 1'b0;
      BusAddr    <= '0;
      BusDataOut <= '0;
`ifdef LIFE_HOST_SEQ_TIMEOUT_EN
      poll_cnt   <= '0;
      Error      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking defaults make every strobe a one-cycle pulse unless a state re-asserts it.
      BusRD <= 1'b0;
      BusWR <= 1'b0;
      Done  <= 1'b0;

      case (state)
        IDLE: begin
          if (Start) begin
            gen_q      <= Generations;
            Busy       <= 1'b1;
            load_cnt   <= '0;
            unload_cnt <= '0;
            state      <= LOAD;
          end
        end

        LOAD: begin
          if (LoadValid) begin
            BusWR      <= 1'b1;
            BusAddr    <= SCAN_ID;
            BusDataOut <= LoadData;
            load_cnt   <= load_cnt + 1'b1;
            if (load_cnt == LAST_WORD) state <= (gen_q == '0) ? UNLOAD : RUN;
          end
        end

        RUN: begin
          BusWR      <= 1'b1;
          BusAddr    <= CTRL_ID;
          BusDataOut <= DWIDTH'(gen_q);
`ifdef LIFE_HOST_SEQ_TIMEOUT_EN
          poll_cnt   <= '0;
`endif
          state      <= POLL;
        end

        POLL: begin
          // BusRD high here means a control read is ending on this edge.
          if (BusRD && BusDataIn[CWIDTH-1:0] == '0) begin
            state <= UNLOAD;
`ifdef LIFE_HOST_SEQ_TIMEOUT_EN
          end else if (BusRD && poll_cnt == POLL_LAST) begin
            state <= ERR;
            Error <= 1'b1;
`endif
          end else begin
            BusRD   <= 1'b1;
            BusAddr <= CTRL_ID;
`ifdef LIFE_HOST_SEQ_TIMEOUT_EN
            if (BusRD) poll_cnt <= poll_cnt + 1'b1;
`endif
          end
        end

        UNLOAD: begin
          if (BusRD) begin
            StoreData  <= BusDataIn;
            StoreValid <= 1'b1;
            unload_cnt <= unload_cnt + 1'b1;
          end else if (StoreValid) begin
            if (StoreReady) begin
              StoreValid <= 1'b0;
              if (unload_cnt == ALL_WORDS) begin
                state <= FINISH;
              end else begin
                BusRD   <= 1'b1;
                BusAddr <= SCAN_ID;
              end
            end
          end else if (unload_cnt != ALL_WORDS) begin
            BusRD   <= 1'b1;
            BusAddr <= SCAN_ID;
          end
        end

        FINISH: begin
          Done  <= 1'b1;
          Busy  <= 1'b0;
          state <= IDLE;
        end

        ERR: ;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_life_host_seq.sv
// Self-checking bench for life_host_seq with a loopback scan-chain/control responder.
// Define LIFE_HOST_SEQ_TIMEOUT_EN to also exercise the poll watchdog.
module tb_life_host_seq;

  localparam int NW = 8;
  localparam logic [7:0] CTRL = 8'hF0;
  localparam logic [7:0] SCAN = 8'hF1;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [7:0]  Generations = '0;
  logic        Busy, Done, LoadReady, StoreValid, BusRD, BusWR, Error;
  logic [31:0] LoadData = '0;
  logic        LoadValid = 1'b0;
  logic        StoreReady = 1'b0;
  logic [31:0] StoreData, BusDataOut, BusDataIn;
  logic [7:0]  BusAddr;

  life_host_seq dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Generations(Generations),
    .Busy(Busy), .Done(Done), .LoadData(LoadData), .LoadValid(LoadValid),
    .LoadReady(LoadReady), .StoreData(StoreData), .StoreValid(StoreValid),
    .StoreReady(StoreReady), .BusRD(BusRD), .BusWR(BusWR), .BusAddr(BusAddr),
    .BusDataOut(BusDataOut), .BusDataIn(BusDataIn), .Error(Error)
  );

  always #5 Clk = ~Clk;

  // Loopback responder: FIFO scan chain plus a control register that counts down on each read.
  logic [31:0] fifo [16];
  logic [3:0]  wp, rp;
  logic [7:0]  ctrl;
  bit          stuck = 1'b0;

  assign BusDataIn = !BusRD ? 32'h0 :
                     (BusAddr == CTRL) ? (stuck ? 32'h5 : {24'h0, ctrl}) : fifo[rp];

  always @(posedge Clk) begin
    if (Reset) begin
      wp <= '0; rp <= '0; ctrl <= '0;
    end else begin
      if (BusWR && BusAddr == SCAN) begin fifo[wp] <= BusDataOut; wp <= wp + 1'b1; end
      if (BusWR && BusAddr == CTRL) ctrl <= BusDataOut[7:0];
      if (BusRD && BusAddr == SCAN) rp <= rp + 1'b1;
      if (BusRD && BusAddr == CTRL && ctrl != 0) ctrl <= ctrl - 1'b1;
    end
  end

  // Bus monitor
  int scan_wr = 0, scan_rd = 0, ctrl_wr = 0, poll_rd = 0, done_cnt = 0, overlap = 0, err_seen = 0;
  int cyc = 0, last_wr_cyc = 0, gap = 0;
  bit wr_pending = 1'b0;
  logic [31:0] last_ctrl_data = '0;

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (!Reset) begin
      if (BusWR && BusRD) overlap <= overlap + 1;
      if (Error) err_seen <= err_seen + 1;
      if (Done) done_cnt <= done_cnt + 1;
      if (BusWR && BusAddr == SCAN) begin
        scan_wr <= scan_wr + 1; last_wr_cyc <= cyc; wr_pending <= 1'b1;
      end
      if (BusWR && BusAddr == CTRL) begin ctrl_wr <= ctrl_wr + 1; last_ctrl_data <= BusDataOut; end
      if (BusRD && BusAddr == CTRL) poll_rd <= poll_rd + 1;
      if (BusRD && BusAddr == SCAN) begin
        scan_rd <= scan_rd + 1;
        if (wr_pending) begin gap <= cyc - last_wr_cyc; wr_pending <= 1'b0; end
      end
    end
  end

  int total = 0, passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0]  gens;
    logic [31:0] base;
    bit          toggle;
    bit          stall;
    bit          spam;
    int          exp_ctrl;
    int          exp_poll;
    int          exp_gap;
  } job_t;

  job_t jobs [4];

  task automatic run_job(input job_t j);
    int sw0 = scan_wr, sr0 = scan_rd, cw0 = ctrl_wr, pr0 = poll_rd, d0 = done_cnt;
    logic [31:0] got [$];
    int acc = 0, k = 0, guard = 0, stall_left, unstable = 0, order_err = 0;
    logic [31:0] held = '0;
    bit held_v = 1'b0;

    @(negedge Clk);
    Generations = j.gens; Start = 1'b1;
    @(negedge Clk);
    Start = j.spam;
    Generations = ~j.gens;
    check("busy_after_start", Busy, 1);

    while (acc < NW && guard < 200) begin
      LoadValid = j.toggle ? (k % 2 == 0) : 1'b1;
      LoadData  = j.base + acc;
      if (LoadValid && LoadReady) acc++;
      k++; guard++;
      @(negedge Clk);
    end
    LoadValid = 1'b0;
    Start = 1'b0;
    check("load_accepted", acc, NW);

    stall_left = j.stall ? 5 : 0;
    guard = 0;
    while (done_cnt == d0 && guard < 600) begin
      if (StoreValid && stall_left > 0) begin
        StoreReady = 1'b0;
        if (held_v && StoreData != held) unstable++;
        held = StoreData; held_v = 1'b1;
        stall_left--;
      end else begin
        StoreReady = 1'b1;
      end
      if (StoreValid && StoreReady) got.push_back(StoreData);
      guard++;
      @(negedge Clk);
    end
    check("done_within_budget", guard < 600, 1);
    repeat (3) @(negedge Clk);

    foreach (got[i]) if (got[i] != j.base + i) order_err++;
    check("scan_writes", scan_wr - sw0, NW);
    check("scan_reads", scan_rd - sr0, NW);
    check("ctrl_writes", ctrl_wr - cw0, j.exp_ctrl);
    if (j.exp_ctrl != 0) check("ctrl_data", last_ctrl_data, {24'h0, j.gens});
    check("poll_reads", poll_rd - pr0, j.exp_poll);
    check("wr_to_rd_gap", gap, j.exp_gap);
    check("store_count", got.size(), NW);
    check("store_order_errs", order_err, 0);
    check("store_stable", unstable, 0);
    check("done_pulses", done_cnt - d0, 1);
    check("idle_busy", Busy, 0);
    check("idle_store_valid", StoreValid, 0);
  endtask

  initial begin
    int acc, d0;
    bit found;

    jobs[0] = '{gens: 8'd3, base: 32'h1,   toggle: 0, stall: 0, spam: 0, exp_ctrl: 1, exp_poll: 4, exp_gap: 7};
    jobs[1] = '{gens: 8'd0, base: 32'h100, toggle: 0, stall: 0, spam: 0, exp_ctrl: 0, exp_poll: 0, exp_gap: 1};
    jobs[2] = '{gens: 8'd1, base: 32'hA0,  toggle: 1, stall: 1, spam: 0, exp_ctrl: 1, exp_poll: 2, exp_gap: 5};
    jobs[3] = '{gens: 8'd2, base: 32'h55,  toggle: 0, stall: 0, spam: 1, exp_ctrl: 1, exp_poll: 3, exp_gap: 6};

    repeat (2) @(negedge Clk);
    check("reset_flags", {Busy, Done, BusRD, BusWR, StoreValid, Error, LoadReady}, 0);
    check("reset_addr", BusAddr, 0);
    check("reset_wdata", BusDataOut, 0);
    check("reset_store_data", StoreData, 0);
    Reset = 1'b0;

    for (int i = 0; i < 4; i++) run_job(jobs[i]);

    // Reset landing on the fourth load write
    d0 = done_cnt;
    @(negedge Clk);
    Generations = 8'd3; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0; LoadValid = 1'b1;
    acc = 0; found = 1'b0;
    for (int g = 0; g < 40 && !found; g++) begin
      LoadData = 32'h200 + acc;
      if (BusWR && BusDataOut == 32'h203) found = 1'b1;
      else begin
        if (LoadReady) acc++;
        @(negedge Clk);
      end
    end
    check("reset_hit_4th_write", found, 1);
    Reset = 1'b1;
    @(negedge Clk);
    check("abort_flags", {Busy, Done, BusRD, BusWR, StoreValid, Error, LoadReady}, 0);
    check("abort_addr", BusAddr, 0);
    check("abort_wdata", BusDataOut, 0);
    check("abort_store_data", StoreData, 0);
    Reset = 1'b0; LoadValid = 1'b0;
    repeat (3) @(negedge Clk);
    check("abort_no_done", done_cnt - d0, 0);
    run_job(jobs[0]);

    check("strobe_overlap", overlap, 0);

`ifdef LIFE_HOST_SEQ_TIMEOUT_EN
    begin
      int pr0, guard;
      stuck = 1'b1;
      pr0 = poll_rd;
      @(negedge Clk);
      Generations = 8'd5; Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0; LoadValid = 1'b1;
      guard = 0;
      while (!Error && guard < 1000) begin
        LoadData = guard;
        guard++;
        @(negedge Clk);
      end
      LoadValid = 1'b0;
      check("wdog_fired", Error, 1);
      check("wdog_poll_reads", poll_rd - pr0, 260);
      repeat (5) @(negedge Clk);
      check("wdog_error_held", Error, 1);
      check("wdog_bus_idle", {BusRD, BusWR}, 0);
      check("wdog_busy_held", Busy, 1);
      Reset = 1'b1;
      @(negedge Clk);
      check("wdog_reset_clears", {Error, Busy}, 0);
      Reset = 1'b0;
      stuck = 1'b0;
    end
`else
    check("error_never_high", err_seen, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
